// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift / upper-fill unit: SLL, SRL, SRA and UPPER, applied at most
// STEP bits per clock under a start/busy/done handshake with a held result.
module iterative_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SW-1:0]    shamt_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL   = 2'b00;
  localparam logic [1:0] MODE_SRL   = 2'b01;
  localparam logic [1:0] MODE_SRA   = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [SW-1:0]    rem_reg, rem_next;
  logic [1:0]       mode_reg, mode_next;
  logic             sign_reg, sign_next;

  logic [SW:0]      step_k;
  logic [SW-1:0]    step_k_trim;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;
  logic [SW-1:0]    load_rem;

  // Operand capture: UPPER pre-clears the high half and shifts it up by WIDTH/2.
  always_comb begin
    load_val = data_i;
    load_rem = shamt_i;
    if (mode_i == MODE_UPPER) begin
      load_val = {{(WIDTH/2){1'b0}}, data_i[WIDTH/2-1:0]};
      load_rem = SW'(WIDTH/2);
    end
  end

  // Per-cycle step: k = min(STEP, rem); k never exceeds rem, so it fits in SW bits.
  always_comb begin
    step_k = {1'b0, rem_reg};
    if ({1'b0, rem_reg} > (SW+1)'(STEP)) begin
      step_k = (SW+1)'(STEP);
    end
    step_k_trim = step_k[SW-1:0];
    fill_mask   = ~({WIDTH{1'b1}} >> step_k);
    case (mode_reg)
      MODE_SRL: shifted = acc_reg >> step_k;
      MODE_SRA: shifted = (acc_reg >> step_k) | (sign_reg ? fill_mask : '0);
      default:  shifted = acc_reg << step_k;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    rem_next    = rem_reg;
    mode_next   = mode_reg;
    sign_next   = sign_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          acc_next  = load_val;
          mode_next = mode_i;
          sign_next = data_i[WIDTH-1];
          rem_next  = load_rem;
          if (load_rem == '0) begin
            result_next = load_val;
            state_next  = DONE;
          end else begin
            state_next  = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_next = shifted;
        rem_next = rem_reg - step_k_trim;
        if (rem_reg == step_k_trim) begin
          result_next = shifted;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      result_reg <= '0;
      rem_reg    <= '0;
      mode_reg   <= MODE_SLL;
      sign_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      rem_reg    <= rem_next;
      mode_reg   <= mode_next;
      sign_reg   <= sign_next;
    end
  end

  assign data_o = result_reg;
  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Scoreboarded random and directed bench for iterative_shift_unit; a forked
// monitor pops expected results whenever done_o is seen.
module tb_iterative_shift_unit;

  localparam int W   = 32;
  localparam int S   = 4;
  localparam int SWL = $clog2(W);

  localparam logic [1:0] SLL   = 2'b00;
  localparam logic [1:0] SRL   = 2'b01;
  localparam logic [1:0] SRA   = 2'b10;
  localparam logic [1:0] UPPER = 2'b11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [W-1:0]   data = '0;
  logic [SWL-1:0] shamt = '0;
  logic [W-1:0]   data_out;
  logic           busy;
  logic           done;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           c0;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;
  logic rst_q = 1'b0;

  iterative_shift_unit #(.WIDTH(W), .STEP(S)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .mode_i (mode),
    .data_i (data),
    .shamt_i(shamt),
    .data_o (data_out),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Reference: plain shift operators; UPPER moves the low half to the top.
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] d, input int sh);
    logic signed [W-1:0] sd;
    sd = d;
    case (m)
      SLL:     return d << sh;
      SRL:     return d >> sh;
      SRA:     return sd >>> sh;
      default: return d << (W/2);
    endcase
  endfunction

  function automatic int latency(input logic [1:0] m, input int sh);
    int n;
    n = (m == UPPER) ? W/2 : sh;
    return (n + S - 1) / S;
  endfunction

  task automatic monitor();
    exp_t         e;
    logic [W-1:0] hold_v;
    bit           prev_done;
    hold_v    = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        q.delete();
        hold_v = '0;
      end
      checks++;
      if (busy !== (q.size() != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (q.size() != 0));
      end
      if (done === 1'b1) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width cyc=%0d done high two cycles running", cyc);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got data=%h want no done", cyc, data_out);
        end else begin
          e = q.pop_front();
          hold_v = e.data;
          checks++;
          if (data_out !== e.data) begin
            errors++;
            $display("FAIL result cyc=%0d got=%h want=%h", cyc, data_out, e.data);
          end
          checks++;
          if (cyc - e.c0 != e.lat) begin
            errors++;
            $display("FAIL latency cyc=%0d got=%0d want=%0d", cyc, cyc - e.c0, e.lat);
          end
          $display("op done cyc=%0d data=%h latency=%0d", cyc, data_out, cyc - e.c0);
        end
        last_done_cyc = cyc;
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_level cyc=%0d got=%b want=0", cyc, done);
        end
      end
      checks++;
      if (data_out !== hold_v) begin
        errors++;
        $display("FAIL data_hold cyc=%0d got=%h want=%h", cyc, data_out, hold_v);
      end
      prev_done = (done === 1'b1);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [W-1:0] d, input int sh,
                       input bit hold, input bit b2b);
    int   waitc;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    while (busy !== 1'b0 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout cyc=%0d busy=%b want 0", cyc, busy);
    end
    mode  = m;
    data  = d;
    shamt = sh[SWL-1:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    e.data = model(m, d, sh);
    e.lat  = latency(m, sh);
    e.c0   = cyc;
    q.push_back(e);
    if (b2b) begin
      checks++;
      if (cyc - last_done_cyc != 2) begin
        errors++;
        $display("FAIL b2b_gap cyc=%0d got=%0d want=2", cyc, cyc - last_done_cyc);
      end
    end
    if (!hold) begin
      start = 1'b0;
      mode  = 2'($urandom);
      data  = W'($urandom);
      shamt = SWL'($urandom);
    end
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while (q.size() != 0 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d want 0", cyc, q.size());
    end
  endtask

  initial begin
    bit prev_hold;
    bit h;
    int sh;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(UPPER, 32'h1234ABCD, 0, 1'b0, 1'b0);
    drain();
    issue(SLL, 32'h00000001, 31, 1'b0, 1'b0);
    drain();
    issue(SRA, 32'h80000000, 5, 1'b0, 1'b0);
    drain();
    issue(SRL, 32'h80000000, 5, 1'b0, 1'b0);
    drain();
    issue(SRL, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    drain();

    // A start pulse during SHIFT must be ignored.
    issue(SLL, 32'h00000001, 20, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = SRL;
    data  = 32'hFFFFFFFF;
    shamt = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Reset in the middle of a long shift abandons it without a done pulse.
    issue(SLL, 32'h00000005, 31, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(SLL, 32'h00000003, 2, 1'b0, 1'b0);
    drain();

    // start held high: back-to-back with one IDLE cycle between operations.
    issue(SRA, 32'hF0000000, 9, 1'b1, 1'b0);
    issue(SLL, 32'h0000ABCD, 0, 1'b1, 1'b1);
    issue(UPPER, 32'hCAFEBABE, 3, 1'b1, 1'b1);
    issue(SRL, 32'h12345678, 31, 1'b1, 1'b1);
    issue(SRA, 32'h87654321, 31, 1'b0, 1'b1);
    drain();

    prev_hold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      h = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0:       sh = 0;
        1:       sh = W - 1;
        default: sh = $urandom_range(0, W - 1);
      endcase
      issue(2'($urandom), W'($urandom), sh, h, prev_hold);
      prev_hold = h;
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
